// File: rtl/conv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port image SRAM between NUM_REQ requesters.
// Optional burst lock is enabled by defining CONV_ARB_BURST_LOCK_EN.
module conv_mem_arbiter #(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 12,
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        arb_en,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     rr;
    logic [IDX_W:0]       pick;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 vld_p0;
    logic                 vld_p1;
    logic [NUM_REQ-1:0]   id_p1;

    // Returns {found, index}; offset 1 from the last grantee has top priority.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last) + k) % NUM_REQ);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

`ifdef CONV_ARB_BURST_LOCK_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    logic [CNT_W-1:0] burst_cnt;
`endif

    // Stage p0: combinational arbitration
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        vld_p0  = 1'b0;
        pick    = rr_pick(req, rr);
`ifdef CONV_ARB_BURST_LOCK_EN
        if ((burst_cnt != '0) && req[rr] && (burst_cnt < CNT_W'(MAX_BURST)))
            pick = {1'b1, rr};
`endif
        if ((state == RUN) && arb_en && pick[IDX_W]) begin
            gnt_idx      = pick[IDX_W-1:0];
            gnt[gnt_idx] = 1'b1;
            vld_p0       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rr    <= IDX_W'(NUM_REQ - 1);
        end else begin
            if (vld_p0) rr <= gnt_idx;
            case (state)
                IDLE:    if (arb_en) state <= RUN;
                RUN:     if (!arb_en) state <= DRAIN;
                // An empty command stage means the return stage empties on this same edge.
                DRAIN:   if (!vld_p1) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_ARB_BURST_LOCK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            burst_cnt <= '0;
        else if (!vld_p0)
            burst_cnt <= '0;
        else if ((gnt_idx != rr) || (burst_cnt == '0))
            burst_cnt <= CNT_W'(1);
        else if (burst_cnt < CNT_W'(MAX_BURST))
            burst_cnt <= burst_cnt + CNT_W'(1);
    end
`endif

    // Stage p1: registered SRAM command
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1    <= 1'b0;
            id_p1     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                id_p1     <= gnt;
                mem_we    <= req_we[gnt_idx];
                mem_addr  <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                mem_wdata <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
            end
        end
    end

    // Stage p2: read return, SRAM data arrives one cycle after the command
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rvalid <= '0;
        else
            rvalid <= (vld_p1 && !mem_we) ? id_p1 : '0;
    end

    assign mem_en = vld_p1;
    assign rdata  = (|rvalid) ? mem_rdata : '0;
    assign busy   = (state == RUN) || (state == DRAIN);

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Directed self-checking bench for conv_mem_arbiter (default build, burst lock disabled).
module tb_conv_mem_arbiter;

    localparam int AW = 17;
    localparam int DW = 12;
    localparam int NR = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             arb_en = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR-1:0]    req_we = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [DW-1:0]    mem_rdata = '0;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    rvalid;
    logic [DW-1:0]    rdata;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             busy;

    int checks = 0;
    int failures = 0;

    conv_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REQ(NR), .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_busy", 32'(busy), 0);

        @(negedge clk);
        rst = 1'b1;
        arb_en = 1'b1;
        #1;
        chk("idle_busy", 32'(busy), 0);

        // all three requesters reading, held six cycles
        req_addr[0*AW +: AW] = 17'h00001;
        req_addr[1*AW +: AW] = 17'h00002;
        req_addr[2*AW +: AW] = 17'h00003;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            req = (k < 6) ? 3'b111 : 3'b000;
            mem_rdata = DW'(12'h100 + k);
            #1;
            chk("rr_gnt", 32'(gnt), (k < 6) ? (1 << (k % 3)) : 0);
            chk("rr_mem_en", 32'(mem_en), (k >= 1 && k <= 6) ? 1 : 0);
            if (k >= 1 && k <= 6)
                chk("rr_mem_addr", 32'(mem_addr), ((k - 1) % 3) + 1);
            chk("rr_rvalid", 32'(rvalid), (k >= 2 && k <= 7) ? (1 << ((k - 2) % 3)) : 0);
            chk("rr_rdata", 32'(rdata), (k >= 2 && k <= 7) ? (32'h100 + k) : 0);
        end

        // single read from requester 1
        @(negedge clk);
        req = 3'b010;
        req_we = 3'b000;
        req_addr[1*AW +: AW] = 17'h00007;
        #1;
        chk("rd_gnt", 32'(gnt), 32'b010);
        @(negedge clk);
        req = 3'b000;
        mem_rdata = 12'hABC;
        #1;
        chk("rd_mem_en", 32'(mem_en), 1);
        chk("rd_mem_we", 32'(mem_we), 0);
        chk("rd_mem_addr", 32'(mem_addr), 32'h7);
        chk("rd_rvalid_early", 32'(rvalid), 0);
        @(negedge clk);
        #1;
        chk("rd_rvalid", 32'(rvalid), 32'b010);
        chk("rd_rdata", 32'(rdata), 32'hABC);
        chk("rd_mem_en_off", 32'(mem_en), 0);

        // single write from requester 0
        @(negedge clk);
        req = 3'b001;
        req_we = 3'b001;
        req_addr[0*AW +: AW] = 17'h00010;
        req_wdata[0*DW +: DW] = 12'h5A5;
        #1;
        chk("wr_gnt", 32'(gnt), 32'b001);
        @(negedge clk);
        req = 3'b000;
        req_we = 3'b000;
        #1;
        chk("wr_mem_en", 32'(mem_en), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h10);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'h5A5);
        @(negedge clk);
        #1;
        chk("wr_rvalid", 32'(rvalid), 0);
        chk("wr_rdata", 32'(rdata), 0);

        // read in flight when arb_en falls, re-enabled during drain
        @(negedge clk);
        req = 3'b100;
        req_addr[2*AW +: AW] = 17'h1FFFF;
        #1;
        chk("dr_gnt", 32'(gnt), 32'b100);
        @(negedge clk);
        arb_en = 1'b0;
        #1;
        chk("dr_gnt_off", 32'(gnt), 0);
        chk("dr_mem_en", 32'(mem_en), 1);
        chk("dr_mem_addr", 32'(mem_addr), 32'h1FFFF);
        chk("dr_busy_run", 32'(busy), 1);
        @(negedge clk);
        arb_en = 1'b1;
        mem_rdata = 12'h3C3;
        #1;
        chk("dr_gnt_drain", 32'(gnt), 0);
        chk("dr_rvalid", 32'(rvalid), 32'b100);
        chk("dr_rdata", 32'(rdata), 32'h3C3);
        chk("dr_busy_drain", 32'(busy), 1);
        @(negedge clk);
        #1;
        chk("dr_busy_idle", 32'(busy), 0);
        chk("dr_gnt_idle", 32'(gnt), 0);
        chk("dr_rvalid_idle", 32'(rvalid), 0);
        @(negedge clk);
        #1;
        chk("dr_busy_rerun", 32'(busy), 1);
        chk("dr_gnt_rerun", 32'(gnt), 32'b100);

        // asynchronous reset with a read just issued
        @(negedge clk);
        rst = 1'b0;
        mem_rdata = 12'hFFF;
        #1;
        chk("ar_mem_en", 32'(mem_en), 0);
        chk("ar_mem_addr", 32'(mem_addr), 0);
        chk("ar_gnt", 32'(gnt), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_rvalid", 32'(rvalid), 0);
        @(negedge clk);
        #1;
        chk("ar_rvalid_next", 32'(rvalid), 0);
        chk("ar_rdata_next", 32'(rdata), 0);
        @(negedge clk);
        rst = 1'b1;
        arb_en = 1'b1;
        req = 3'b111;
        #1;
        chk("ar_idle_busy", 32'(busy), 0);
        chk("ar_idle_gnt", 32'(gnt), 0);
        @(negedge clk);
        #1;
        chk("ar_first_gnt", 32'(gnt), 32'b001);
        @(negedge clk);
        #1;
        chk("ar_second_gnt", 32'(gnt), 32'b010);

        // requests withdrawn: no grant, no command afterwards
        @(negedge clk);
        req = 3'b000;
        #1;
        chk("nr_gnt", 32'(gnt), 0);
        chk("nr_mem_en_last", 32'(mem_en), 1);
        @(negedge clk);
        #1;
        chk("nr_mem_en", 32'(mem_en), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
